// File: rtl/dmem_pkg.sv
// Shared types and address helpers for the data memory responder.
// The word index and range check are kept here so every consumer decodes addresses identically.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // Unsigned 32-bit offset from the base, so addresses below the base wrap to huge indices.
    function automatic logic [31:0] word_index(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        logic [31:0] offset;
        offset = addr - base;
        return offset >> $clog2(WORD_BYTES);
    endfunction

    function automatic logic access_ok(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] index,
        input int unsigned depth
    );
        return (addr[1:0] == 2'b00) && (addr >= base) && (index < depth);
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Word-port handshake between the load/store unit (master) and the memory responder (slave).
// One request is held until ready, one single-cycle rvalid pulse comes back per request.
interface data_memory_responder_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ready,
        input  rvalid,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ready,
        output rvalid,
        output rdata,
        output err
    );

endinterface

// File: rtl/dmem_word_ram.sv
// Single-port word storage with synchronous write and registered read; contents are never reset.
// The read register holds its value whenever no read is enabled.
module dmem_word_ram #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic                           i_re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [31:0]                    i_wdata,
    output logic [31:0]                    o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for the 32-bit load/store word port: one request in flight,
// programmable wait states, commit on the edge entering RESP, one-cycle response pulse.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    data_memory_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        w_accept;
    logic        w_commit;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        r_zero;

    logic        w_c_we;
    logic [31:0] w_c_addr;
    logic [31:0] w_c_wdata;
    logic [31:0] w_c_index;
    logic        w_c_ok;
    logic [31:0] w_ram_rdata;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = bus.req;
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = RESP;
                    w_commit     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                w_accept = bus.req;
                if (!bus.req) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // With no wait states the accept edge is also the commit edge.
        if (w_accept) begin
            if (WAIT_STATES == 0) begin
                w_state_next = RESP;
                w_commit     = 1'b1;
            end else begin
                w_state_next = WAIT;
                w_cnt_next   = 4'(WAIT_STATES - 1);
            end
        end
    end

    // Committing from WAIT uses the latched request; otherwise the request is being accepted now.
    always_comb begin
        if (r_state == WAIT) begin
            w_c_we    = r_we;
            w_c_addr  = r_addr;
            w_c_wdata = r_wdata;
        end else begin
            w_c_we    = bus.we;
            w_c_addr  = bus.addr;
            w_c_wdata = bus.wdata;
        end
    end

    assign w_c_index = word_index(w_c_addr, BASE_ADDR);
    assign w_c_ok    = access_ok(w_c_addr, BASE_ADDR, w_c_index, DEPTH_WORDS);

    dmem_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_commit & w_c_we & w_c_ok),
        .i_re    (w_commit & ~w_c_we & w_c_ok),
        .i_addr  (w_c_index[AW-1:0]),
        .i_wdata (w_c_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= bus.we;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
            end
            // Write acks and errors return zero; the flag holds so rdata stays put until the next commit.
            if (w_commit) begin
                r_err  <= ~w_c_ok;
                r_zero <= w_c_we | ~w_c_ok;
            end
        end
    end

    assign bus.ready  = (r_state != WAIT);
    assign bus.rvalid = (r_state == RESP);
    assign bus.err    = (r_state == RESP) & r_err;
    assign bus.rdata  = r_zero ? 32'd0 : w_ram_rdata;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized bench for data_memory_responder: four parameterizations, each checked every cycle
// against a transaction-level model (response queue keyed by cycle, word array, busy window).
module tb_data_memory_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gap;
        bit          kill;
    } req_t;

    typedef struct {
        int          cyc;
        int          pres;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } pend_t;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t actual=%h required=%h", name, inst, $time, act, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] a, input logic [31:0] base, input int depth);
        longint off;
        off = longint'({32'h0, a}) - longint'({32'h0, base});
        return (a % 4 != 0) || (off < 0) || ((off / 4) >= depth);
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_inst
        localparam int WS            = (gi == 0) ? 0 : (gi == 1) ? 3 : (gi == 2) ? 2 : 1;
        localparam int DEPTH         = (gi == 0) ? 1024 : (gi == 1) ? 256 : (gi == 2) ? 128 : 64;
        localparam logic [31:0] BASE = (gi == 3) ? 32'h0000_1000 : 32'h0000_0000;

        logic rst;
        int   cyc = 0;
        bit   fin = 1'b0;

        data_memory_responder_if bus ();

        data_memory_responder #(
            .DEPTH_WORDS (DEPTH),
            .WAIT_STATES (WS),
            .BASE_ADDR   (BASE)
        ) dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus.slave)
        );

        logic [31:0] mem   [DEPTH];
        bit          known [DEPTH];
        pend_t       pend_q[$];
        req_t        stim[$];
        int          busy_from = 1;
        int          busy_to   = 0;
        logic [31:0] last_rd   = 32'd0;
        bit          last_known = 1'b1;
        logic [31:0] log_rd  [64];
        bit          log_err [64];
        int          log_lat [64];
        int          n_log = 0;

        always @(posedge clk) cyc <= cyc + 1;

        // Compare process: every falling edge, outputs against the model.
        initial begin
            bit          exp_v;
            bit          e_err;
            bit          e_known;
            logic [31:0] e_rd;
            int          idx;
            pend_t       p;
            forever begin
                @(negedge clk);
                if (rst) begin
                    chk("rst_ready",  gi, 32'(bus.ready),  32'd1);
                    chk("rst_rvalid", gi, 32'(bus.rvalid), 32'd0);
                    chk("rst_err",    gi, 32'(bus.err),    32'd0);
                    chk("rst_rdata",  gi, bus.rdata,       32'd0);
                end else begin
                    exp_v = (pend_q.size() > 0) && (pend_q[0].cyc == cyc);
                    chk("ready",  gi, 32'(bus.ready),  32'(!(cyc >= busy_from && cyc <= busy_to)));
                    chk("rvalid", gi, 32'(bus.rvalid), 32'(exp_v));
                    if (exp_v) begin
                        p       = pend_q.pop_front();
                        e_err   = model_err(p.addr, BASE, DEPTH);
                        e_rd    = 32'd0;
                        e_known = 1'b1;
                        if (!e_err) begin
                            idx = int'((p.addr - BASE) / 4);
                            if (p.we) begin
                                mem[idx]   = p.wdata;
                                known[idx] = 1'b1;
                            end else begin
                                e_rd    = mem[idx];
                                e_known = known[idx];
                            end
                        end
                        chk("err", gi, 32'(bus.err), 32'(e_err));
                        if (e_known) chk("rdata", gi, bus.rdata, e_rd);
                        last_rd    = e_rd;
                        last_known = e_known;
                        if (n_log < 64) begin
                            log_rd[n_log]  = bus.rdata;
                            log_err[n_log] = bus.err;
                            log_lat[n_log] = cyc - p.pres;
                            n_log++;
                        end
                        $display("inst%0d cyc=%0d %s addr=%h wdata=%h rdata=%h err=%0d", gi, cyc,
                                 p.we ? "WR" : "RD", p.addr, p.wdata, bus.rdata, bus.err);
                    end else begin
                        chk("idle_err", gi, 32'(bus.err), 32'd0);
                        if (last_known) chk("rdata_hold", gi, bus.rdata, last_rd);
                    end
                end
            end
        end

        // Driver: requests held until the model says they are accepted.
        initial begin
            req_t        s;
            int          w;
            int          g;
            int          pres;
            logic [31:0] a;
            rst       = 1'b1;
            bus.req   = 1'b0;
            bus.we    = 1'b0;
            bus.addr  = 32'd0;
            bus.wdata = 32'd0;

            for (int i = 0; i < 20; i++)
                stim.push_back(req_t'{1'b1, BASE + 32'(4 * i), 32'hA000_0000 + 32'(i), 0, 1'b0});
            if (gi == 0) begin
                stim.push_back(req_t'{1'b1, 32'h10, 32'hDEAD_BEEF, 2, 1'b0});
                stim.push_back(req_t'{1'b0, 32'h10, 32'h0, 2, 1'b0});
                stim.push_back(req_t'{1'b0, 32'h20, 32'h0, 2, 1'b0});
                stim.push_back(req_t'{1'b0, 32'h24, 32'h0, 0, 1'b0});
                stim.push_back(req_t'{1'b0, 32'h28, 32'h0, 0, 1'b0});
                stim.push_back(req_t'{1'b0, 32'h2C, 32'h0, 0, 1'b0});
                stim.push_back(req_t'{1'b1, 32'h13, 32'h5555_AAAA, 1, 1'b0});
                stim.push_back(req_t'{1'b1, 32'h1000, 32'h6666_7777, 1, 1'b0});
                stim.push_back(req_t'{1'b0, 32'h10, 32'h0, 1, 1'b0});
            end else if (gi == 1) begin
                stim.push_back(req_t'{1'b0, 32'h0, 32'h0, 3, 1'b0});
                stim.push_back(req_t'{1'b0, 32'h4, 32'h0, 0, 1'b0});
            end else if (gi == 2) begin
                stim.push_back(req_t'{1'b1, 32'h40, 32'h1234_5678, 2, 1'b1});
                stim.push_back(req_t'{1'b0, 32'h40, 32'h0, 2, 1'b0});
            end else begin
                stim.push_back(req_t'{1'b0, 32'h0000_0FFC, 32'h0, 1, 1'b0});
                stim.push_back(req_t'{1'b0, 32'h0000_1000, 32'h0, 1, 1'b0});
                stim.push_back(req_t'{1'b0, 32'h0000_1100, 32'h0, 1, 1'b0});
                stim.push_back(req_t'{1'b0, 32'hFFFF_FFFC, 32'h0, 1, 1'b0});
            end

            for (int i = 0; i < 120; i++) begin
                w = int'($urandom_range(0, 19));
                a = BASE + 32'(4 * w);
                case ($urandom_range(0, 15))
                    0:       a = a + 32'($urandom_range(1, 3));
                    1:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
                    2:       a = BASE - 32'(4 * $urandom_range(1, 4));
                    default: ;
                endcase
                g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
                stim.push_back(req_t'{1'($urandom_range(0, 1)), a, $urandom, g, 1'b0});
            end

            repeat (2) @(posedge clk);
            #1 rst = 1'b0;

            foreach (stim[k]) begin
                s       = stim[k];
                bus.req = 1'b0;
                repeat (s.gap) begin
                    @(posedge clk);
                    #1;
                end
                bus.req   = 1'b1;
                bus.we    = s.we;
                bus.addr  = s.addr;
                bus.wdata = s.wdata;
                pres      = cyc;
                while (cyc >= busy_from && cyc <= busy_to) begin
                    @(posedge clk);
                    #1;
                end
                pend_q.push_back(pend_t'{cyc + 1 + WS, pres, s.we, s.addr, s.wdata});
                busy_from = cyc + 1;
                busy_to   = cyc + WS;
                @(posedge clk);
                #1;
                if (s.kill) begin
                    // Reset lands while the write is still waiting: it must vanish entirely.
                    bus.req    = 1'b0;
                    rst        = 1'b1;
                    pend_q.delete();
                    busy_from  = 1;
                    busy_to    = 0;
                    last_rd    = 32'd0;
                    last_known = 1'b1;
                    @(posedge clk);
                    #1 rst = 1'b0;
                end
            end
            bus.req = 1'b0;
            repeat (WS + 4) @(posedge clk);
            #1;
            chk("drained", gi, 32'(pend_q.size()), 32'd0);
            fin = 1'b1;
        end
    end

    initial begin
        int t;
        bit all_fin;
        t       = 0;
        all_fin = 1'b0;
        while (!all_fin && t < 20000) begin
            @(posedge clk);
            t++;
            all_fin = g_inst[0].fin && g_inst[1].fin && g_inst[2].fin && g_inst[3].fin;
        end
        chk("finish_in_time", -1, 32'(all_fin), 32'd1);

        // Hand-derived expectations pinning the model.
        chk("wr_ack_latency",   0, 32'(g_inst[0].log_lat[20]), 32'd1);
        chk("rd_latency",       0, 32'(g_inst[0].log_lat[21]), 32'd1);
        chk("rd_after_wr",      0, g_inst[0].log_rd[21],       32'hDEAD_BEEF);
        chk("rd_after_wr_err",  0, 32'(g_inst[0].log_err[21]), 32'd0);
        chk("vec_word0",        0, g_inst[0].log_rd[22],       32'hA000_0008);
        chk("vec_word3",        0, g_inst[0].log_rd[25],       32'hA000_000B);
        chk("vec_word3_lat",    0, 32'(g_inst[0].log_lat[25]), 32'd1);
        chk("misalign_err",     0, 32'(g_inst[0].log_err[26]), 32'd1);
        chk("misalign_rdata",   0, g_inst[0].log_rd[26],       32'd0);
        chk("oor_err",          0, 32'(g_inst[0].log_err[27]), 32'd1);
        chk("word4_unchanged",  0, g_inst[0].log_rd[28],       32'hDEAD_BEEF);
        chk("ws3_rdata",        1, g_inst[1].log_rd[20],       32'hA000_0000);
        chk("ws3_latency",      1, 32'(g_inst[1].log_lat[20]), 32'd4);
        chk("ws3_held_latency", 1, 32'(g_inst[1].log_lat[21]), 32'd7);
        chk("ws3_held_rdata",   1, g_inst[1].log_rd[21],       32'hA000_0001);
        chk("post_rst_rdata",   2, g_inst[2].log_rd[20],       32'hA000_0010);
        chk("post_rst_err",     2, 32'(g_inst[2].log_err[20]), 32'd0);
        chk("post_rst_latency", 2, 32'(g_inst[2].log_lat[20]), 32'd3);
        chk("below_base_err",   3, 32'(g_inst[3].log_err[20]), 32'd1);
        chk("below_base_rdata", 3, g_inst[3].log_rd[20],       32'd0);
        chk("base_word0_err",   3, 32'(g_inst[3].log_err[21]), 32'd0);
        chk("base_word0_rdata", 3, g_inst[3].log_rd[21],       32'hA000_0000);
        chk("past_end_err",     3, 32'(g_inst[3].log_err[22]), 32'd1);
        chk("wrap_err",         3, 32'(g_inst[3].log_err[23]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
